// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT/IFFT butterfly datapaths.
// Samples are packed complex words {re, im}, each component a signed
// fixed-point value (Q1.15 at the default 32-bit width).
package fft_pkg;

    localparam int CPLX_W = 32;
    localparam int COMP_W = CPLX_W / 2;
    localparam int Q_FRAC = COMP_W - 1;

    localparam logic signed [COMP_W-1:0] CPLX_MAX = {1'b0, {(COMP_W-1){1'b1}}};
    localparam logic signed [COMP_W-1:0] CPLX_MIN = {1'b1, {(COMP_W-1){1'b0}}};

    // Width of the intermediate that sat_cplx_comp() works on.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [COMP_W-1:0] re;
        logic signed [COMP_W-1:0] im;
    } cplx_t;

    function automatic logic signed [COMP_W-1:0] cplx_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic logic signed [COMP_W-1:0] cplx_im(input cplx_t c);
        return c.im;
    endfunction

    // Clamp a sign-extended value to the signed range of a comp_w-bit
    // component. The result stays SAT_W bits wide; the caller keeps the low
    // comp_w bits and compares against the input to detect clamping.
    function automatic logic signed [SAT_W-1:0] sat_cplx_comp(
        input logic signed [SAT_W-1:0] v,
        input int                      comp_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        if (comp_w == COMP_W) begin
            hi = SAT_W'(CPLX_MAX);
            lo = SAT_W'(CPLX_MIN);
        end else begin
            hi = (64'sd1 <<< (comp_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (comp_w - 1));
        end
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/cmul_conj_stage.sv
// Conjugate-twiddle multiply for the inverse butterfly's b path.
// Stage 2 registers the four partial products of conj(w) * d; stage 3
// combines them, divides by 2^(WIDTH/2) (Q1.15 scaling plus the /2 of the
// inverse butterfly) with floor truncation, saturates and registers b.
module cmul_conj_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = CPLX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adv_i,
    input  logic                    s1_valid_i,
    input  logic                    s2_valid_i,
    input  logic [WIDTH-1:0]        w_i,
    input  logic signed [WIDTH/2:0] d_re_i,
    input  logic signed [WIDTH/2:0] d_im_i,
    output logic [WIDTH-1:0]        b_o,
    output logic                    sat_o
);

    localparam int H    = WIDTH / 2;
    // Fraction bits of a component; the shift below removes them plus one
    // more bit for the halving.
    localparam int FRAC = (WIDTH == CPLX_W) ? Q_FRAC : H - 1;
    localparam int PW   = WIDTH + 1;    // H x (H+1) signed product
    localparam int SW   = WIDTH + 2;    // sum of two products

    logic signed [H-1:0] w_re;
    logic signed [H-1:0] w_im;

    assign w_re = w_i[WIDTH-1:H];
    assign w_im = w_i[H-1:0];

    // ---------------- stage 2: partial products ----------------
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    // Full-width signed products of the twiddle and the S1 difference.
    always_comb begin
        p_rr_d = PW'(w_re) * PW'(d_re_i);
        p_ii_d = PW'(w_im) * PW'(d_im_i);
        p_ri_d = PW'(w_re) * PW'(d_im_i);
        p_ir_d = PW'(w_im) * PW'(d_re_i);
    end

    // Product registers load only when a real sample moves into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (adv_i && s1_valid_i) begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
        end
    end

    // ---------------- stage 3: combine and saturate ----------------
    logic signed [SW-1:0]    p_re, p_im;
    logic signed [SAT_W-1:0] sh_re, sh_im;
    logic signed [SAT_W-1:0] cl_re, cl_im;
    logic [WIDTH-1:0]        b_d;
    logic                    sat_d;
    logic [WIDTH-1:0]        b_q;
    logic                    sat_q;

    // conj(w)*d: re = wr*dr + wi*di, im = wr*di - wi*dr; then floor-shift
    // and clamp each component, flagging any clamp.
    always_comb begin
        p_re  = SW'(p_rr_q) + SW'(p_ii_q);
        p_im  = SW'(p_ri_q) - SW'(p_ir_q);
        sh_re = SAT_W'(p_re >>> (FRAC + 1));
        sh_im = SAT_W'(p_im >>> (FRAC + 1));
        cl_re = sat_cplx_comp(sh_re, H);
        cl_im = sat_cplx_comp(sh_im, H);
        b_d   = {H'(cl_re), H'(cl_im)};
        sat_d = (cl_re != sh_re) || (cl_im != sh_im);
    end

    // Output register for b and its saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            sat_q <= 1'b0;
        end else if (adv_i && s2_valid_i) begin
            b_q   <= b_d;
            sat_q <= sat_d;
        end
    end

    assign b_o   = b_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Three-stage pipelined inverse radix-2 butterfly:
//   a = (x1 + x2) / 2,   b = conj(w) * (x1 - x2) / 2
// S1 forms sum/difference, S2 multiplies (in cmul_conj_stage), S3 produces
// the registered a/b/sat outputs. A tag rides alongside each sample.
//
// Stream handshake: on each side a sample moves when valid && ready at a
// rising clock edge. valid must not depend on ready. The whole pipe advances
// together when the output register is empty or being drained
// (adv = !out_valid || out_ready); in_ready is exactly adv, so when adv is
// low every stage, including bubbles, holds its contents.
module ifft_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH = CPLX_W,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [TAG_W-1:0] out_tag,
    output logic             sat
);

    localparam int H = WIDTH / 2;
    localparam int E = H + 1;   // sum/difference width, cannot overflow

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: sum and difference ----------------
    logic signed [H-1:0] x1_re, x1_im, x2_re, x2_im;

    assign x1_re = x1[WIDTH-1:H];
    assign x1_im = x1[H-1:0];
    assign x2_re = x2[WIDTH-1:H];
    assign x2_im = x2[H-1:0];

    logic signed [E-1:0] s1_s_re_d, s1_s_im_d, s1_d_re_d, s1_d_im_d;
    logic signed [E-1:0] s1_s_re_q, s1_s_im_q, s1_d_re_q, s1_d_im_q;
    logic [WIDTH-1:0]    s1_w_q;
    logic [TAG_W-1:0]    s1_tag_q;
    logic                s1_valid_q;

    // Sign-extend by one bit before adding so sum and difference are exact.
    always_comb begin
        s1_s_re_d = E'(x1_re) + E'(x2_re);
        s1_s_im_d = E'(x1_im) + E'(x2_im);
        s1_d_re_d = E'(x1_re) - E'(x2_re);
        s1_d_im_d = E'(x1_im) - E'(x2_im);
    end

    // Stage 1 valid follows the input on every advance; data loads on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_s_re_q  <= '0;
            s1_s_im_q  <= '0;
            s1_d_re_q  <= '0;
            s1_d_im_q  <= '0;
            s1_w_q     <= '0;
            s1_tag_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_s_re_q <= s1_s_re_d;
                s1_s_im_q <= s1_s_im_d;
                s1_d_re_q <= s1_d_re_d;
                s1_d_im_q <= s1_d_im_d;
                s1_w_q    <= w;
                s1_tag_q  <= in_tag;
            end
        end
    end

    // ---------------- stage 2: sum and tag pass through ----------------
    logic signed [E-1:0] s2_s_re_q, s2_s_im_q;
    logic [TAG_W-1:0]    s2_tag_q;
    logic                s2_valid_q;

    // The sum waits one stage while the products are being formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_s_re_q  <= '0;
            s2_s_im_q  <= '0;
            s2_tag_q   <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_s_re_q <= s1_s_re_q;
                s2_s_im_q <= s1_s_im_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // b path: S2 products and S3 combine/saturate.
    cmul_conj_stage #(
        .WIDTH (WIDTH)
    ) u_cmul (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (adv),
        .s1_valid_i (s1_valid_q),
        .s2_valid_i (s2_valid_q),
        .w_i        (s1_w_q),
        .d_re_i     (s1_d_re_q),
        .d_im_i     (s1_d_im_q),
        .b_o        (b),
        .sat_o      (sat)
    );

    // ---------------- stage 3: a path and output register ----------------
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_valid_q;

    // Halving by arithmetic shift floors; the result always fits H bits.
    always_comb begin
        a_d = {H'(s2_s_re_q >>> 1), H'(s2_s_im_q >>> 1)};
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                a_q       <= a_d;
                out_tag_q <= s2_tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Bench for ifft_butterfly_pipe: directed vectors, latency, back-to-back
// streaming, output stall, mid-stream reset, randomized exact-model traffic
// and a forward/inverse round trip with tolerance.
module tb_ifft_butterfly_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 8;
    // Expected entry: {round_trip, a[31:0], b[31:0], tag[7:0], sat}
    localparam int EXP_W = 1 + 2 * WIDTH + TAG_W + 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x1, x2, w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a, b;
    logic [TAG_W-1:0] out_tag;
    logic             sat;

    always #5 clk = ~clk;

    ifft_butterfly_pipe #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .w         (w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .out_tag   (out_tag),
        .sat       (sat)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: held low

    logic [EXP_W-1:0] exp_q[$];
    int               hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking task ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint n, input longint k);
        if (n >= 0) return n / k;
        return -((-n + k - 1) / k);
    endfunction

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Returns {a, b, sat} from the butterfly's arithmetic definition.
    function automatic logic [2*WIDTH:0] ref_model(input logic [31:0] x1v, input logic [31:0] x2v,
                                                   input logic [31:0] wv);
        longint x1r, x1i, x2r, x2i, wr, wi, ar, ai, dr, di, pr, pi, br, bi, cbr, cbi;
        logic [15:0] ar16, ai16, br16, bi16;
        x1r = longint'($signed(x1v[31:16]));
        x1i = longint'($signed(x1v[15:0]));
        x2r = longint'($signed(x2v[31:16]));
        x2i = longint'($signed(x2v[15:0]));
        wr  = longint'($signed(wv[31:16]));
        wi  = longint'($signed(wv[15:0]));
        ar  = floor_div(x1r + x2r, 2);
        ai  = floor_div(x1i + x2i, 2);
        dr  = x1r - x2r;
        di  = x1i - x2i;
        pr  = wr * dr + wi * di;
        pi  = wr * di - wi * dr;
        br  = floor_div(pr, 65536);
        bi  = floor_div(pi, 65536);
        cbr = clamp16(br);
        cbi = clamp16(bi);
        ar16 = 16'(ar);
        ai16 = 16'(ai);
        br16 = 16'(cbr);
        bi16 = 16'(cbi);
        return {ar16, ai16, br16, bi16, (cbr != br) || (cbi != bi)};
    endfunction

    function automatic logic [EXP_W-1:0] mk_exp(input logic [31:0] x1v, input logic [31:0] x2v,
                                                input logic [31:0] wv, input logic [7:0] tg);
        logic [2*WIDTH:0] m;
        m = ref_model(x1v, x2v, wv);
        return {1'b0, m[2*WIDTH:1], tg, m[0]};
    endfunction

    function automatic int comp_err(input logic [15:0] got, input logic [15:0] exp);
        int d;
        d = int'($signed(got)) - int'($signed(exp));
        return (d < 0) ? -d : d;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic                     held_v = 1'b0;
    logic [2*WIDTH+TAG_W:0]   held;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        int err;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid_held", out_valid, 1'b1);
                check("stall_data_held", {a, b, out_tag, sat}, held);
            end
            held_v = out_valid && !out_ready;
            held   = {a, b, out_tag, sat};
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[EXP_W-1]) begin
                        err = comp_err(a[31:16], e[72:57]);
                        check("rt_a_re_err_gt1", (err > 1) ? err : 0, 0);
                        err = comp_err(a[15:0], e[56:41]);
                        check("rt_a_im_err_gt1", (err > 1) ? err : 0, 0);
                        err = comp_err(b[31:16], e[40:25]);
                        check("rt_b_re_err_gt2", (err > 2) ? err : 0, 0);
                        err = comp_err(b[15:0], e[24:9]);
                        check("rt_b_im_err_gt2", (err > 2) ? err : 0, 0);
                        check("rt_tag", out_tag, e[8:1]);
                    end else begin
                        check("out_a", a, e[72:41]);
                        check("out_b", b, e[40:9]);
                        check("out_tag", out_tag, e[8:1]);
                        check("out_sat", sat, e[0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive(input logic [31:0] x1v, input logic [31:0] x2v, input logic [31:0] wv,
                         input logic [7:0] tg, input logic [EXP_W-1:0] e);
        logic accepted;
        accepted = 1'b0;
        x1       = x1v;
        x2       = x2v;
        w        = wv;
        in_tag   = tg;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("input_accepted", accepted, 1'b1);
    endtask

    task automatic drive_rand(input logic [7:0] tg);
        logic [31:0] x1v, x2v, wv;
        x1v = $urandom;
        x2v = $urandom;
        wv  = $urandom;
        drive(x1v, x2v, wv, tg, mk_exp(x1v, x2v, wv, tg));
    endtask

    // Forward butterfly with round-to-nearest, then queue the originals.
    task automatic drive_round_trip(input logic [7:0] tg);
        int     ar, ai, br, bi, wr, wi, wbr, wbi;
        real    ang;
        ar  = int'($urandom_range(0, 16383)) - 8192;
        ai  = int'($urandom_range(0, 16383)) - 8192;
        br  = int'($urandom_range(0, 8191)) - 4096;
        bi  = int'($urandom_range(0, 8191)) - 4096;
        ang = 6.283185307179586 * real'($urandom_range(0, 65535)) / 65536.0;
        wr  = $rtoi($floor(32767.0 * $cos(ang) + 0.5));
        wi  = $rtoi($floor(32767.0 * $sin(ang) + 0.5));
        wbr = int'(floor_div(longint'(wr) * br - longint'(wi) * bi + 16384, 32768));
        wbi = int'(floor_div(longint'(wr) * bi + longint'(wi) * br + 16384, 32768));
        drive({16'(ar + wbr), 16'(ai + wbi)}, {16'(ar - wbr), 16'(ai - wbi)},
              {16'(wr), 16'(wi)}, tg,
              {1'b1, 16'(ar), 16'(ai), 16'(br), 16'(bi), tg, 1'b0});
    endtask

    // Called right after drive() of a lone sample into an empty pipe.
    task automatic check_latency(input string tag);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(tag, lat, 3);
    endtask

    // Waits for the scoreboard to empty; returns at posedge+1.
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic drive_done;

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x1        = '0;
        x2        = '0;
        w         = '0;
        in_tag    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_a", a, 32'h0);
        check("rst_b", b, 32'h0);
        check("rst_out_tag", out_tag, 8'h0);
        check("rst_sat", sat, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector 1 with latency
        drive(32'h2000_1000, 32'h1000_0800, 32'h7FFF_0000, 8'h5A,
              {1'b0, 32'h1800_0C00, 32'h07FF_03FF, 8'h5A, 1'b0});
        check_latency("latency_vec1");
        wait_drain("drain_vec1");

        // Directed vector 2: saturating b
        drive(32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000, 8'hA5,
              {1'b0, 32'hFFFF_FFFF, 32'h7FFF_0000, 8'hA5, 1'b1});
        check_latency("latency_vec2");
        wait_drain("drain_vec2");

        // Back-to-back stream of 16
        hs_cyc.delete();
        for (int i = 0; i < 16; i++) drive_rand(8'(8'h10 + i));
        wait_drain("drain_b2b");
        check("b2b_count", hs_cyc.size(), 16);
        if (hs_cyc.size() == 16) check("b2b_span", hs_cyc[15] - hs_cyc[0], 15);

        // Output stall while full
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive_rand(8'(8'h40 + i));
        drive_done = 1'b0;
        fork
            begin
                drive_rand(8'h43);
                drive_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
        end
        rdy_mode = 0;
        for (int n = 0; n < 50 && !drive_done; n++) @(negedge clk);
        check("stall_release_accept", drive_done, 1'b1);
        @(posedge clk);
        #1;
        wait_drain("drain_stall");

        // Reset with three in flight
        for (int i = 0; i < 3; i++) drive_rand(8'(8'h60 + i));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_a", a, 32'h0);
        check("midrst_b", b, 32'h0);
        check("midrst_tag", out_tag, 8'h0);
        check("midrst_sat", sat, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_rand(8'h77);
        check_latency("latency_after_reset");
        wait_drain("drain_after_reset");

        // Randomized traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            drive_rand(8'(i));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("drain_random");

        // Forward/inverse round trip
        for (int i = 0; i < 1000; i++) begin
            drive_round_trip(8'(i));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("drain_round_trip");

        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
